// File: rtl/demux_frame_router.sv
// demux_frame_router: serial frame receiver that feeds the 1:4 demultiplexer.
// Frame (MSB first): start bit, 2 address bits, 8 data bits, optional even
// parity bit, stop bit. A good frame latches sel/data_out and pulses the
// one-hot chan_valid strobe. A bad frame pulses frame_err instead.
// Optional feature macro: DEMUX_FRAME_PARITY_EN (adds the parity bit and PAR state).
module demux_frame_router #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       sample_en,
  output logic [1:0] sel,
  output logic [7:0] data_out,
  output logic [3:0] chan_valid,
  output logic       busy,
  output logic       frame_err
);

`ifdef DEMUX_FRAME_PARITY_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, STOP} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic        addr_cnt;
  logic [2:0]  data_cnt;
  logic [1:0]  addr_sr;
  logic [7:0]  data_sr;
  logic        frame_done;
  logic        frame_good;
`ifdef DEMUX_FRAME_PARITY_EN
  logic        par_bit;
`endif

  // State register; reset wins over any same-cycle line activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and stop-bit evaluation; nothing moves without sample_en.
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    frame_good = 1'b0;
    if (sample_en) begin
      case (state)
        IDLE: begin
          if (serial_in != IDLE_LEVEL) begin
            state_nxt = ADDR;
          end
        end
        ADDR: begin
          if (addr_cnt) begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (data_cnt == 3'd7) begin
`ifdef DEMUX_FRAME_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = STOP;
`endif
          end
        end
`ifdef DEMUX_FRAME_PARITY_EN
        PAR: begin
          state_nxt = STOP;
        end
`endif
        STOP: begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
`ifdef DEMUX_FRAME_PARITY_EN
          frame_good = (serial_in == IDLE_LEVEL) &&
                       ((^{addr_sr, data_sr, par_bit}) == 1'b0);
`else
          frame_good = (serial_in == IDLE_LEVEL);
`endif
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Shift registers, bit counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt   <= 1'b0;
      data_cnt   <= 3'd0;
      addr_sr    <= 2'b00;
      data_sr    <= 8'h00;
`ifdef DEMUX_FRAME_PARITY_EN
      par_bit    <= 1'b0;
`endif
      sel        <= 2'b00;
      data_out   <= 8'h00;
      chan_valid <= 4'h0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      chan_valid <= 4'h0;
      frame_err  <= 1'b0;
      busy       <= (state_nxt != IDLE);
      if (sample_en) begin
        if (state == ADDR) begin
          addr_sr  <= {addr_sr[0], serial_in};
          addr_cnt <= ~addr_cnt;
        end
        if (state == DATA) begin
          data_sr  <= {data_sr[6:0], serial_in};
          data_cnt <= data_cnt + 3'd1;
        end
`ifdef DEMUX_FRAME_PARITY_EN
        if (state == PAR) begin
          par_bit <= serial_in;
        end
`endif
      end
      if (frame_done) begin
        if (frame_good) begin
          sel        <= addr_sr;
          data_out   <= data_sr;
          chan_valid <= 4'b0001 << addr_sr;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_frame_router.sv
// tb_demux_frame_router: directed frames against a bit-list frame model,
// checked every cycle, plus literal expectations at key points.
module tb_demux_frame_router;

  localparam logic IDLE = 1'b1;
`ifdef DEMUX_FRAME_PARITY_EN
  localparam int FLEN = 12;
`else
  localparam int FLEN = 11;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       sample_en;
  logic [1:0] sel;
  logic [7:0] data_out;
  logic [3:0] chan_valid;
  logic       busy;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic [1:0]  m_sel  = 2'b00;
  logic [7:0]  m_data = 8'h00;
  logic [3:0]  m_cv   = 4'h0;
  logic        m_busy = 1'b0;
  logic        m_ferr = 1'b0;
  bit          m_inframe = 1'b0;
  int          m_nbits = 0;
  logic [15:0] m_frame = 16'h0;
  logic [1:0]  m_a;
  logic [7:0]  m_d;
  logic        m_ok;

  always #5 clk = ~clk;

  demux_frame_router dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .sample_en  (sample_en),
    .sel        (sel),
    .data_out   (data_out),
    .chan_valid (chan_valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic en, input logic r);
    rst       = r;
    serial_in = b;
    sample_en = en;
    @(negedge clk);
  endtask

  // Junk on the line while sample_en is low must be ignored.
  task automatic sendBit(input logic b, input int stride);
    repeat (stride - 1) applyStimulus(~b, 1'b0, 1'b0);
    applyStimulus(b, 1'b1, 1'b0);
  endtask

  task automatic sendFrame(input logic [1:0] a, input logic [7:0] d, input logic stop,
                           input logic par, input int stride, input bit rst_at_stop);
    sendBit(~IDLE, stride);
    for (int i = 1; i >= 0; i--) sendBit(a[i], stride);
    for (int i = 7; i >= 0; i--) sendBit(d[i], stride);
`ifdef DEMUX_FRAME_PARITY_EN
    sendBit(par, stride);
`endif
    if (rst_at_stop) begin
      repeat (stride - 1) applyStimulus(~stop, 1'b0, 1'b0);
      applyStimulus(stop, 1'b1, 1'b1);
    end else begin
      sendBit(stop, stride);
    end
  endtask

  function automatic logic even_par(input logic [1:0] a, input logic [7:0] d);
    return ^{a, d};
  endfunction

  // Frame model: collect sampled bits after a start bit, judge the frame once complete.
  initial begin
    forever begin
      @(posedge clk);
      m_cv   = 4'h0;
      m_ferr = 1'b0;
      if (rst) begin
        m_inframe = 1'b0;
        m_nbits   = 0;
        m_frame   = 16'h0;
        m_sel     = 2'b00;
        m_data    = 8'h00;
      end else if (sample_en) begin
        if (!m_inframe) begin
          if (serial_in !== IDLE) begin
            m_inframe = 1'b1;
            m_nbits   = 0;
            m_frame   = 16'h0;
          end
        end else begin
          m_frame = {m_frame[14:0], serial_in};
          m_nbits++;
          if (m_nbits == FLEN) begin
            m_a  = m_frame[FLEN-1 -: 2];
            m_d  = m_frame[FLEN-3 -: 8];
            m_ok = (m_frame[0] === IDLE);
`ifdef DEMUX_FRAME_PARITY_EN
            m_ok = m_ok && ((^m_frame[FLEN-1:1]) == 1'b0);
`endif
            if (m_ok) begin
              m_sel  = m_a;
              m_data = m_d;
              m_cv   = 4'b0001 << m_a;
            end else begin
              m_ferr = 1'b1;
            end
            m_inframe = 1'b0;
          end
        end
      end
      m_busy = m_inframe;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("cyc_sel", {6'b0, sel}, {6'b0, m_sel});
        checkOutput("cyc_data", data_out, m_data);
        checkOutput("cyc_chan_valid", {4'b0, chan_valid}, {4'b0, m_cv});
        checkOutput("cyc_busy", {7'b0, busy}, {7'b0, m_busy});
        checkOutput("cyc_frame_err", {7'b0, frame_err}, {7'b0, m_ferr});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    serial_in = IDLE;
    sample_en = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    applyStimulus(IDLE, 1'b1, 1'b1);

    // Idle line after reset
    repeat (20) applyStimulus(IDLE, 1'b1, 1'b0);
    checkOutput("rst_sel", {6'b0, sel}, 8'h00);
    checkOutput("rst_data", data_out, 8'h00);
    checkOutput("rst_chan_valid", {4'b0, chan_valid}, 8'h00);
    checkOutput("rst_busy", {7'b0, busy}, 8'h00);
    checkOutput("rst_frame_err", {7'b0, frame_err}, 8'h00);

    // Good frame addr=10 data=A5
    sendFrame(2'b10, 8'hA5, IDLE, even_par(2'b10, 8'hA5), 1, 1'b0);
    checkOutput("a5_chan_valid", {4'b0, chan_valid}, 8'h04);
    checkOutput("a5_sel", {6'b0, sel}, 8'h02);
    checkOutput("a5_data", data_out, 8'hA5);
    checkOutput("a5_frame_err", {7'b0, frame_err}, 8'h00);
    checkOutput("a5_busy_fall", {7'b0, busy}, 8'h00);
    applyStimulus(IDLE, 1'b1, 1'b0);
    checkOutput("a5_pulse_end", {4'b0, chan_valid}, 8'h00);

    // Same frame, sample_en every third cycle
    sendFrame(2'b10, 8'hA5, IDLE, even_par(2'b10, 8'hA5), 3, 1'b0);
    checkOutput("slow_chan_valid", {4'b0, chan_valid}, 8'h04);
    checkOutput("slow_data", data_out, 8'hA5);
    applyStimulus(IDLE, 1'b0, 1'b0);
    checkOutput("slow_pulse_end", {4'b0, chan_valid}, 8'h00);
    applyStimulus(IDLE, 1'b1, 1'b0);

    // Bad stop bit: error pulse, outputs retained
    sendFrame(2'b01, 8'h3C, ~IDLE, even_par(2'b01, 8'h3C), 1, 1'b0);
    checkOutput("badstop_frame_err", {7'b0, frame_err}, 8'h01);
    checkOutput("badstop_chan_valid", {4'b0, chan_valid}, 8'h00);
    checkOutput("badstop_sel", {6'b0, sel}, 8'h02);
    checkOutput("badstop_data", data_out, 8'hA5);
    applyStimulus(IDLE, 1'b1, 1'b0);
    checkOutput("badstop_pulse_end", {7'b0, frame_err}, 8'h00);

    // Reset after 5th data bit of an addr=11 frame
    sendBit(~IDLE, 1);
    sendBit(1'b1, 1);
    sendBit(1'b1, 1);
    for (int i = 7; i >= 3; i--) sendBit(8'h5A >> i, 1);
    applyStimulus(IDLE, 1'b1, 1'b1);
    checkOutput("abort_sel", {6'b0, sel}, 8'h00);
    checkOutput("abort_data", data_out, 8'h00);
    checkOutput("abort_busy", {7'b0, busy}, 8'h00);
    repeat (3) applyStimulus(IDLE, 1'b1, 1'b0);
    sendFrame(2'b00, 8'hFF, IDLE, even_par(2'b00, 8'hFF), 1, 1'b0);
    checkOutput("ff_chan_valid", {4'b0, chan_valid}, 8'h01);
    checkOutput("ff_data", data_out, 8'hFF);

    // Back-to-back frames
    sendFrame(2'b01, 8'h3C, IDLE, even_par(2'b01, 8'h3C), 1, 1'b0);
    checkOutput("b2b1_chan_valid", {4'b0, chan_valid}, 8'h02);
    sendFrame(2'b11, 8'h81, IDLE, even_par(2'b11, 8'h81), 1, 1'b0);
    checkOutput("b2b2_chan_valid", {4'b0, chan_valid}, 8'h08);
    checkOutput("b2b2_data", data_out, 8'h81);

    // Reset coinciding with the stop-bit sample
    sendFrame(2'b10, 8'h42, IDLE, even_par(2'b10, 8'h42), 1, 1'b1);
    checkOutput("rststop_chan_valid", {4'b0, chan_valid}, 8'h00);
    checkOutput("rststop_sel", {6'b0, sel}, 8'h00);
    checkOutput("rststop_data", data_out, 8'h00);
    applyStimulus(IDLE, 1'b1, 1'b0);

`ifdef DEMUX_FRAME_PARITY_EN
    // Parity good then parity bad
    sendFrame(2'b11, 8'h01, IDLE, 1'b1, 1, 1'b0);
    checkOutput("par_ok_chan_valid", {4'b0, chan_valid}, 8'h08);
    checkOutput("par_ok_data", data_out, 8'h01);
    applyStimulus(IDLE, 1'b1, 1'b0);
    sendFrame(2'b11, 8'h02, IDLE, 1'b0, 1, 1'b0);
    checkOutput("par_bad_frame_err", {7'b0, frame_err}, 8'h01);
    checkOutput("par_bad_chan_valid", {4'b0, chan_valid}, 8'h00);
    checkOutput("par_bad_data", data_out, 8'h01);
    applyStimulus(IDLE, 1'b1, 1'b0);
`endif

    repeat (5) applyStimulus(IDLE, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_frame_router.md
# demux_frame_router

Serial frame receiver that sits directly upstream of the 1:4 demultiplexer and produces its select and data. Decodes a framed serial bitstream carrying a 2-bit channel address and an 8-bit payload, latches both, and emits a one-cycle one-hot strobe on the addressed channel. Downstream routing logic consumes `sel`, `data_out` and `chan_valid`.

## Interface
- `IDLE_LEVEL`, default 1: line level between frames; start bit is its inverse.
- `clk`  in  1  rising-edge clock, sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  serial line, sampled only when `sample_en`=1.
- `sample_en`  in  1  bit strobe; one bit consumed per cycle where high.
- `sel`  out  2  channel address of last good frame.
- `data_out`  out  8  payload of last good frame.
- `chan_valid`  out  4  one-hot, 1-cycle pulse: bit `sel` on good frame.
- `busy`  out  1  high from start-bit detection until frame end.
- `frame_err`  out  1  1-cycle pulse on bad stop (or parity) bit.

## Operation
- Frame, MSB first: start bit (!`IDLE_LEVEL`), 2 address bits, 8 data bits, [parity bit], stop bit (`IDLE_LEVEL`).
- FSM: IDLE -> ADDR (start bit seen) -> DATA (2 addr bits taken) -> PAR (8 data bits taken, parity build only) -> STOP -> IDLE. Without parity, DATA -> STOP directly.
- Transitions advance only on cycles with `sample_en`=1; `sample_en`=0 holds all state, counters and shift registers.
- Bit counter 3 bits for DATA, 1 bit for ADDR; wraps to 0 on state exit.
- IDLE: line at `IDLE_LEVEL` with `sample_en`=1 stays IDLE, no activity.
- STOP with correct level: `sel`<=address, `data_out`<=payload, `chan_valid`<=4'b0001<<address, return IDLE.
- STOP with wrong level (or parity mismatch): `frame_err` pulse, `sel`/`data_out` keep previous values, `chan_valid` stays 0, return IDLE (no resync hunting; next start bit detected normally).
- `sel`/`data_out` update only on good frames; stable otherwise.

## Timing
- Reset values: state IDLE, `sel`=2'b00, `data_out`=8'h00, `chan_valid`=4'h0, `busy`=0, `frame_err`=0, shift registers and counters 0.
- All outputs registered. `chan_valid`/`frame_err` assert in the cycle after the edge that samples the stop bit, for exactly one cycle, then 0 regardless of `sample_en`.
- `busy` rises the cycle after the start-bit sample edge; falls in the same cycle `chan_valid`/`frame_err` asserts.
- Back-to-back: a start bit sampled in the cycle immediately after the stop bit is accepted; pulse of previous frame and `busy` rise coincide.
- Minimum frame: 12 `sample_en` cycles (13 with parity).
- `rst` has priority over everything including a same-cycle stop bit; mid-frame reset aborts the frame with no pulse and returns all outputs to reset values on the next cycle.

## Configuration
- `DEMUX_FRAME_PARITY_EN` defined: even parity bit after data; parity computed over 2 address + 8 data bits; mismatch -> `frame_err` at STOP (stop level still checked, one pulse only), outputs not updated.
- Undefined: no PAR state, no parity bit on the line; `frame_err` from stop bit only.

## Test plan
- Reset, `sample_en`=1 every cycle, line idle 20 cycles -> all outputs at reset values, `busy`=0 throughout.
- Frame addr=2'b10, data=8'hA5, good stop -> `sel`=2'b10, `data_out`=8'hA5, `chan_valid`=4'b0100 for one cycle, `frame_err`=0.
- Same frame with `sample_en` high only every 3rd cycle -> identical result; pulse width still one clock.
- Frame addr=2'b01, data=8'h3C, stop bit 0 -> `frame_err` 1-cycle pulse, `chan_valid`=0, `sel`/`data_out` retain 2'b10/8'hA5.
- Assert `rst` for one cycle after 5th data bit of addr=2'b11 frame, then send addr=2'b00 data=8'hFF -> no pulse for aborted frame; then `chan_valid`=4'b0001, `data_out`=8'hFF.
- With `DEMUX_FRAME_PARITY_EN`: addr=2'b11, data=8'h01 (ones=3) with parity bit 1 -> `chan_valid`=4'b1000; same frame with parity 0 -> `frame_err` pulse only.
